// File: rtl/count_ones_hs.sv
// count_ones_hs: handshaked population-count engine.
// Accepts a word on start/ready and counts ones (mode=0) or zeros (mode=1).
// It examines BITS_PER_CYCLE bits per clock and stops early once the
// remaining bits are all zero. The result is shown with a one-cycle done pulse.
module count_ones_hs #(
  parameter int DATA_WIDTH     = 8,
  parameter int BITS_PER_CYCLE = 2,
  parameter int COUNT_WIDTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic                   mode,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] bit_count
);

  localparam int NUM_CYC = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int CYC_W   = $clog2(NUM_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [DATA_WIDTH-1:0]  shreg;
  logic [COUNT_WIDTH-1:0] acc;
  logic [CYC_W-1:0]       cyc;

  logic [COUNT_WIDTH-1:0] addend;
  logic [COUNT_WIDTH-1:0] acc_sum;
  logic [DATA_WIDTH-1:0]  shifted;
  logic [CYC_W-1:0]       cyc_dec;
  logic                   finish;

  // Number of set bits in one slice of the shift register.
  function automatic logic [COUNT_WIDTH-1:0] popcount(
    input logic [BITS_PER_CYCLE-1:0] v
  );
    logic [COUNT_WIDTH-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      cnt = cnt + COUNT_WIDTH'(v[i]);
    end
    return cnt;
  endfunction

  // Per-cycle arithmetic for the COUNT step and the early-exit test.
  // The exit test looks at the post-shift word, so a word whose upper bits
  // are zero finishes without spending cycles on those empty slices.
  always_comb begin
    addend  = popcount(shreg[BITS_PER_CYCLE-1:0]);
    acc_sum = acc + addend;
    shifted = shreg >> BITS_PER_CYCLE;
    cyc_dec = cyc - CYC_W'(1);
    finish  = (shifted == '0) || (cyc_dec == '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the handshake outputs, which are decoded from state only.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = COUNT;
      end
      COUNT: begin
        busy = 1'b1;
        if (finish) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on accept, shift/accumulate while counting, publish on exit.
  // bit_count is written only on the final COUNT cycle, so it never shows partial sums.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg     <= '0;
      acc       <= '0;
      cyc       <= '0;
      bit_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= mode ? ~data : data;
            acc   <= '0;
            cyc   <= CYC_W'(NUM_CYC);
          end
        end
        COUNT: begin
          acc   <= acc_sum;
          shreg <= shifted;
          cyc   <= cyc_dec;
          if (finish) bit_count <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule
